// File: rtl/reg_write_encoder.sv
// reg_write_encoder: collects pending register-write requests and issues them
// one index per handshake, round-robin over registers 1..15.
// Ports: clk, rst_n (async active-low), req_in/req_ld (merge requests),
//        flush (sync clear), out_valid/out_ready/idx (output handshake),
//        pending (registered request mask), busy (out_valid | |pending).
module reg_write_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_in,
    input  logic        req_ld,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  idx,
    output logic [15:0] pending,
    output logic        busy
);

    logic [3:0]  ptr;
    logic [15:0] load_mask;
    logic        stage_free;
    logic [3:0]  sel;
    logic        sel_ok;
    logic [3:0]  start0;
    logic [4:0]  pos;
    logic [3:0]  cand;
    logic        do_issue;
    logic [15:0] issued_bit;

    // Register 0 has no decoder line, so its request bit is dropped.
    assign load_mask  = req_ld ? (req_in & 16'hFFFE) : 16'h0000;
    assign stage_free = !out_valid || out_ready;
    assign busy       = out_valid | (|pending);

    // Round-robin search over registers 1..15 starting after ptr.
    // Positions 0..14 map to registers 1..15; ptr=0 and ptr=15 both
    // start the search at register 1.
    always_comb begin
        sel    = 4'd0;
        sel_ok = 1'b0;
        pos    = 5'd0;
        cand   = 4'd0;
        start0 = (ptr == 4'd15) ? 4'd0 : ptr;
        for (int i = 0; i < 15; i++) begin
            pos = {1'b0, start0} + 5'(i);
            if (pos >= 5'd15) begin
                pos = pos - 5'd15;
            end
            cand = pos[3:0] + 4'd1;
            if (!sel_ok && pending[cand]) begin
                sel    = cand;
                sel_ok = 1'b1;
            end
        end
    end

    assign do_issue   = !flush && stage_free && sel_ok;
    assign issued_bit = do_issue ? (16'h0001 << sel) : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 16'h0000;
            idx       <= 4'd0;
            out_valid <= 1'b0;
            ptr       <= 4'd0;
        end else if (flush) begin
            pending   <= load_mask;
            out_valid <= 1'b0;
        end else begin
            // A reload of the bit issued this edge keeps it set.
            pending <= (pending & ~issued_bit) | load_mask;
            if (stage_free) begin
                if (sel_ok) begin
                    idx       <= sel;
                    out_valid <= 1'b1;
                    ptr       <= sel;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
